// File: rtl/vga_tile_writer_if.sv
// Tile update / clear / BMEM write bundle between game logic and vga_tile_writer.
// master = game-side driver (and scan-out vblank source), slave = the writer.
interface vga_tile_writer_if #(
   parameter int DATA_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic [4:0]        req_x;
   logic [4:0]        req_y;
   logic [DATA_W-1:0] req_data;
   logic              clear_req;
   logic [DATA_W-1:0] clear_data;
   logic              clear_busy;
   logic              vblank;
   logic              we;
   logic [9:0]        waddr;
   logic [DATA_W-1:0] wdata;
   logic              req_err;

   modport master (
      output req_valid, req_x, req_y, req_data, clear_req, clear_data, vblank,
      input  req_ready, clear_busy, we, waddr, wdata, req_err
   );

   modport slave (
      input  req_valid, req_x, req_y, req_data, clear_req, clear_data, vblank,
      output req_ready, clear_busy, we, waddr, wdata, req_err
   );
endinterface

// File: rtl/vga_tile_writer.sv
// Write side of the 32x24 tile BMEM: request FIFO, single writer FSM, full-screen clear.
// Define VGA_WRITER_VBLANK_EN to restrict all BMEM writes to vblank.
module vga_tile_writer #(
   parameter int XTILES     = 32,
   parameter int YTILES     = 24,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input logic              clk,
   input logic              reset,
   vga_tile_writer_if.slave bus
);

   localparam int          AW    = $clog2(FIFO_DEPTH);
   localparam int          EW    = 10 + DATA_W;
   localparam logic [4:0]  XLAST = 5'(XTILES - 1);
   localparam logic [4:0]  YLAST = 5'(YTILES - 1);
   localparam logic [4:0]  YLIM  = 5'(YTILES);

   typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

   state_t            state;
   logic [EW-1:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic              write_ok;
   logic [4:0]        pop_x;
   logic [4:0]        pop_y;
   logic [DATA_W-1:0] pop_data;
   logic [4:0]        cx;
   logic [4:0]        cy;
   logic [DATA_W-1:0] cdata;
   logic              clear_pend;

`ifdef VGA_WRITER_VBLANK_EN
   assign write_ok = bus.vblank;
`else
   logic unused_vblank;
   assign unused_vblank = bus.vblank;
   assign write_ok      = 1'b1;
`endif

   assign full          = (count == (AW+1)'(FIFO_DEPTH));
   assign empty         = (count == '0);
   assign bus.req_ready = ~full;
   assign push          = bus.req_valid & ~full;
   assign {pop_y, pop_x, pop_data} = mem[rd_ptr];

   // A new or deferred clear always wins over draining the FIFO.
   assign pop = (state != CLEAR) & ~bus.clear_req & ~clear_pend & ~empty & write_ok;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {bus.req_y, bus.req_x, bus.req_data};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         bus.we         <= 1'b0;
         bus.waddr      <= '0;
         bus.wdata      <= '0;
         bus.clear_busy <= 1'b0;
         bus.req_err    <= 1'b0;
         cx             <= '0;
         cy             <= '0;
         cdata          <= '0;
         clear_pend     <= 1'b0;
      end else begin
         bus.we      <= 1'b0;
         bus.req_err <= 1'b0;
         case (state)
            IDLE: begin
               bus.clear_busy <= 1'b0;
               if (bus.clear_req | clear_pend) begin
                  state          <= CLEAR;
                  bus.clear_busy <= 1'b1;
                  clear_pend     <= 1'b0;
                  cx             <= '0;
                  cy             <= '0;
                  if (bus.clear_req) cdata <= bus.clear_data;
               end
            end
            WRITE: begin
               if (bus.clear_req) begin
                  clear_pend <= 1'b1;
                  cdata      <= bus.clear_data;
               end
               if (!pop) state <= IDLE;
            end
            CLEAR: begin
               // clear_busy stays high through the last write and drops in IDLE.
               if (write_ok) begin
                  bus.we    <= 1'b1;
                  bus.waddr <= {cy, cx};
                  bus.wdata <= cdata;
                  if (cx == XLAST) begin
                     cx <= '0;
                     if (cy == YLAST) state <= IDLE;
                     else             cy <= cy + 1'b1;
                  end else begin
                     cx <= cx + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         if (pop) begin
            state <= WRITE;
            if (pop_y >= YLIM) begin
               bus.req_err <= 1'b1;
            end else begin
               bus.we    <= 1'b1;
               bus.waddr <= {pop_y, pop_x};
               bus.wdata <= pop_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_tile_writer.sv
// Scoreboard bench for vga_tile_writer: expected BMEM writes queued at stimulus time, popped per we.
module tb_vga_tile_writer;

   typedef struct {
      logic [9:0] addr;
      logic [7:0] data;
      logic       is_clear;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   we_count = 0;
   int   err_count = 0;

   always #5 clk = ~clk;

   vga_tile_writer_if #(.DATA_W(8)) bus ();

   vga_tile_writer #(
      .XTILES(32), .YTILES(24), .DATA_W(8), .FIFO_DEPTH(4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (bus.req_err) err_count++;
            if (bus.we) begin
               we_count++;
               vectors++;
               if (sb.size() == 0) begin
                  miscompares++;
                  $display("FAIL unexpected_write: waddr=%h wdata=%h, no write expected", bus.waddr, bus.wdata);
               end else begin
                  e = sb.pop_front();
                  if (bus.waddr !== e.addr || bus.wdata !== e.data ||
                      (e.is_clear && bus.clear_busy !== 1'b1)) begin
                     miscompares++;
                     $display("FAIL write: waddr=%h wdata=%h busy=%b, expected waddr=%h wdata=%h busy=%b",
                              bus.waddr, bus.wdata, bus.clear_busy, e.addr, e.data, e.is_clear);
                  end
               end
            end
         end
      end
   endtask

   // Called at a negedge; returns at the negedge after acceptance with req_valid still high.
   task automatic send_req(input logic [4:0] x, input logic [4:0] y, input logic [7:0] d);
      int   t = 0;
      exp_t e;
      bus.req_valid = 1'b1;
      bus.req_x = x;
      bus.req_y = y;
      bus.req_data = d;
      while (!bus.req_ready && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (!bus.req_ready) begin
         vectors++;
         miscompares++;
         $display("FAIL req_accept_timeout: req_ready=%b, required 1", bus.req_ready);
      end else if (y < 5'd24) begin
         e.addr = {y, x};
         e.data = d;
         e.is_clear = 1'b0;
         sb.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic push_clear(input logic [7:0] d);
      exp_t e;
      for (int i = 0; i < 768; i++) begin
         e.addr = 10'(i);
         e.data = d;
         e.is_clear = 1'b1;
         sb.push_back(e);
      end
   endtask

   task automatic start_clear(input logic [7:0] d);
      bus.clear_req = 1'b1;
      bus.clear_data = d;
      push_clear(d);
      @(negedge clk);
      bus.clear_req = 1'b0;
   endtask

   task automatic wait_busy_low();
      int t = 0;
      while (bus.clear_busy && t < 2000) begin
         @(negedge clk);
         t++;
      end
   endtask

   task automatic wait_drain();
      int t = 0;
      while (sb.size() != 0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      vectors += 6;
      if (bus.we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b, required 0", bus.we); end
      if (bus.waddr !== 10'h000) begin miscompares++; $display("FAIL reset_waddr: got %h, required 000", bus.waddr); end
      if (bus.wdata !== 8'h00) begin miscompares++; $display("FAIL reset_wdata: got %h, required 00", bus.wdata); end
      if (bus.clear_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, required 0", bus.clear_busy); end
      if (bus.req_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b, required 0", bus.req_err); end
      if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b, required 1", bus.req_ready); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if (bus.we !== 1'b0 || bus.req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL post_reset: we=%b ready=%b, required we=0 ready=1", bus.we, bus.req_ready);
      end
   endtask

   task automatic test_single();
      exp_t e;
      bus.req_valid = 1'b1;
      bus.req_x = 5'd5;
      bus.req_y = 5'd3;
      bus.req_data = 8'hA5;
      e.addr = 10'h065;
      e.data = 8'hA5;
      e.is_clear = 1'b0;
      sb.push_back(e);
      @(negedge clk);
      bus.req_valid = 1'b0;
      vectors++;
      if (bus.we !== 1'b0) begin miscompares++; $display("FAIL latency_n1: we=%b, required 0", bus.we); end
      @(negedge clk);
      vectors++;
      if (bus.we !== 1'b1 || bus.waddr !== 10'h065) begin
         miscompares++;
         $display("FAIL latency_n2: we=%b waddr=%h, required we=1 waddr=065", bus.we, bus.waddr);
      end
      @(negedge clk);
      vectors++;
      if (bus.we !== 1'b0) begin miscompares++; $display("FAIL single_pulse: we=%b, required 0", bus.we); end
      wait_drain();
   endtask

   task automatic test_clear();
      int w0 = we_count;
      start_clear(8'h00);
      vectors++;
      if (bus.clear_busy !== 1'b1) begin miscompares++; $display("FAIL clear_busy_rise: got %b, required 1", bus.clear_busy); end
      wait_busy_low();
      vectors += 3;
      if (bus.clear_busy !== 1'b0) begin miscompares++; $display("FAIL clear_timeout: busy=%b, required 0", bus.clear_busy); end
      if (we_count - w0 != 768) begin miscompares++; $display("FAIL clear_count: got %0d writes, required 768", we_count - w0); end
      if (sb.size() != 0) begin miscompares++; $display("FAIL clear_left: %0d writes missing, required 0", sb.size()); end
   endtask

   task automatic test_burst();
      start_clear(8'h11);
      for (int i = 0; i < 4; i++) send_req(5'(i), 5'(i + 1), 8'(8'h30 + i));
      vectors++;
      if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL burst_full: ready=%b, required 0", bus.req_ready); end
      for (int i = 4; i < 6; i++) send_req(5'(i), 5'(i + 1), 8'(8'h30 + i));
      bus.req_valid = 1'b0;
      wait_drain();
      vectors += 2;
      if (sb.size() != 0) begin miscompares++; $display("FAIL burst_left: %0d writes missing, required 0", sb.size()); end
      if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL burst_ready: ready=%b, required 1", bus.req_ready); end
   endtask

   task automatic test_bad_row();
      int e0 = err_count;
      int w0 = we_count;
      send_req(5'd7, 5'd24, 8'hEE);
      bus.req_valid = 1'b0;
      repeat (4) @(negedge clk);
      vectors += 2;
      if (err_count - e0 != 1) begin miscompares++; $display("FAIL bad_row_err: got %0d pulses, required 1", err_count - e0); end
      if (we_count != w0) begin miscompares++; $display("FAIL bad_row_we: got %0d writes, required 0", we_count - w0); end
      send_req(5'd9, 5'd23, 8'h5A);
      bus.req_valid = 1'b0;
      wait_drain();
      vectors += 2;
      if (sb.size() != 0) begin miscompares++; $display("FAIL after_bad_row: %0d writes missing, required 0", sb.size()); end
      if (err_count - e0 != 1) begin miscompares++; $display("FAIL bad_row_once: got %0d pulses, required 1", err_count - e0); end
   endtask

   task automatic test_clear_with_queue();
      exp_t e;
      int   w0 = we_count;
      bus.clear_req = 1'b1;
      bus.clear_data = 8'hFF;
      bus.req_valid = 1'b1;
      bus.req_x = 5'd3;
      bus.req_y = 5'd4;
      bus.req_data = 8'hC1;
      push_clear(8'hFF);
      e.addr = {5'd4, 5'd3};
      e.data = 8'hC1;
      e.is_clear = 1'b0;
      sb.push_back(e);
      @(negedge clk);
      bus.clear_req = 1'b0;
      bus.req_x = 5'd31;
      bus.req_y = 5'd0;
      bus.req_data = 8'hC2;
      e.addr = {5'd0, 5'd31};
      e.data = 8'hC2;
      sb.push_back(e);
      @(negedge clk);
      bus.req_valid = 1'b0;
      vectors++;
      if (bus.clear_busy !== 1'b1) begin miscompares++; $display("FAIL cq_busy: got %b, required 1", bus.clear_busy); end
      wait_busy_low();
      wait_drain();
      vectors += 2;
      if (sb.size() != 0) begin miscompares++; $display("FAIL cq_left: %0d writes missing, required 0", sb.size()); end
      if (we_count - w0 != 770) begin miscompares++; $display("FAIL cq_count: got %0d writes, required 770", we_count - w0); end
   endtask

`ifdef VGA_WRITER_VBLANK_EN
   task automatic test_vblank_burst();
      bus.vblank = 1'b0;
      for (int i = 0; i < 4; i++) send_req(5'(i + 10), 5'(i + 2), 8'(8'h60 + i));
      vectors++;
      if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL vb_full: ready=%b, required 0", bus.req_ready); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vectors++;
         if (bus.we !== 1'b0) begin miscompares++; $display("FAIL vb_hold: we=%b, required 0", bus.we); end
      end
      bus.vblank = 1'b1;
      for (int i = 4; i < 6; i++) send_req(5'(i + 10), 5'(i + 2), 8'(8'h60 + i));
      bus.req_valid = 1'b0;
      wait_drain();
      vectors += 2;
      if (sb.size() != 0) begin miscompares++; $display("FAIL vb_left: %0d writes missing, required 0", sb.size()); end
      if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL vb_ready: ready=%b, required 1", bus.req_ready); end
   endtask

   task automatic test_vblank_clear();
      int t = 0;
      int w0 = we_count;
      start_clear(8'h77);
      while (!(bus.we && bus.waddr == 10'h049) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      bus.vblank = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         vectors++;
         if (bus.we !== 1'b0 || bus.clear_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL vb_pause: we=%b busy=%b, required we=0 busy=1", bus.we, bus.clear_busy);
         end
      end
      bus.vblank = 1'b1;
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (bus.we !== 1'b1 || bus.waddr !== 10'h04A) begin
         miscompares++;
         $display("FAIL vb_resume: we=%b waddr=%h, required we=1 waddr=04a", bus.we, bus.waddr);
      end
      wait_busy_low();
      vectors += 2;
      if (we_count - w0 != 768) begin miscompares++; $display("FAIL vb_count: got %0d writes, required 768", we_count - w0); end
      if (sb.size() != 0) begin miscompares++; $display("FAIL vb_clear_left: %0d writes missing, required 0", sb.size()); end
   endtask
`endif

   task automatic test_reset_mid_clear();
      int w0;
      start_clear(8'h55);
      send_req(5'd1, 5'd2, 8'h99);
      bus.req_valid = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      reset = 1'b1;
      sb.delete();
      #1;
      vectors++;
      if (bus.clear_busy !== 1'b0 || bus.we !== 1'b0 || bus.req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_reset: busy=%b we=%b ready=%b, required 0 0 1", bus.clear_busy, bus.we, bus.req_ready);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      w0 = we_count;
      send_req(5'd2, 5'd2, 8'h42);
      bus.req_valid = 1'b0;
      wait_drain();
      vectors += 2;
      if (sb.size() != 0) begin miscompares++; $display("FAIL post_mid_reset: %0d writes missing, required 0", sb.size()); end
      if (we_count - w0 != 1) begin miscompares++; $display("FAIL flush: got %0d writes, required 1", we_count - w0); end
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_x = '0;
      bus.req_y = '0;
      bus.req_data = '0;
      bus.clear_req = 1'b0;
      bus.clear_data = '0;
      bus.vblank = 1'b1;
      fork
         monitor();
      join_none
      test_reset();
      test_single();
      test_clear();
      test_burst();
      test_bad_row();
      test_clear_with_queue();
`ifdef VGA_WRITER_VBLANK_EN
      test_vblank_burst();
      test_vblank_clear();
`endif
      test_reset_mid_clear();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
